// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } uart_tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Longest frame: start + 8 data + parity + 2 stop.
  localparam int MAX_FRAME_BITS = 1 + 8 + 1 + 2;

  function automatic logic parity_bit(input logic [7:0] data,
                                      input int         nbits,
                                      input int         mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p ^= data[i];
    end
    return p ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: tick marks the last clock of the current bit.
module uart_baud_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Holding at zero instead of wrapping keeps an all-ones divisor safe.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames the pending byte and drives the tx pin.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0,
  parameter int DVSR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              full,
  input  logic              tx_start,
  input  logic [7:0]        data_in,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tx,
  output logic              tx_done,
  output logic              busy
);

  localparam int IDX_W = $clog2(MAX_FRAME_BITS);

  uart_tx_state_e    state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              cnt_load, cnt_en, tick;
  logic [DVSR_W-1:0] cnt_val;

  assign cnt_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                  (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_baud_cnt #(.W(DVSR_W)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (cnt_val),
    .tick_o     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    dvsr_d   = dvsr_q;
    idx_d    = idx_q;
    par_d    = par_q;
    cnt_load = 1'b0;
    cnt_val  = dvsr_q;
    unique case (state_q)
      ST_IDLE: if (full && tx_start) begin
        state_d  = ST_START;
        shift_d  = data_in;
        dvsr_d   = dvsr;
        par_d    = parity_bit(data_in, DATA_BITS, PARITY);
        cnt_load = 1'b1;
        cnt_val  = dvsr;
      end
      ST_START: if (tick) begin
        state_d  = ST_DATA;
        idx_d    = '0;
        cnt_load = 1'b1;
      end
      ST_DATA: if (tick) begin
        cnt_load = 1'b1;
        shift_d  = shift_q >> 1;
        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
          idx_d   = '0;
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_PARITY: if (tick) begin
        state_d  = ST_STOP;
        idx_d    = '0;
        cnt_load = 1'b1;
      end
      ST_STOP: if (tick) begin
        if (idx_q == IDX_W'(STOP_BITS - 1)) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          cnt_load = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered, so they
  // line up with the state without any input-to-output combinational path.
  always_comb begin
    tx_d   = 1'b1;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_START:  tx_d   = 1'b0;
      ST_DATA:   tx_d   = shift_d[0];
      ST_PARITY: tx_d   = par_d;
      ST_DONE:   done_d = 1'b1;
      default:   tx_d   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      dvsr_q  <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: an 8N1 and an 8E2 instance checked against a frame-level model.
module tb_uart_tx_ctrl;

  typedef logic [2:0] exp_t;        // {tx, busy, tx_done}
  typedef exp_t exp_q_t[$];
  localparam exp_t EXP_IDLE = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        full_a = 1'b0, start_a = 1'b0, full_b = 1'b0, start_b = 1'b0;
  logic [7:0]  data_a = '0, data_b = '0;
  logic [31:0] dvsr_a = '0, dvsr_b = '0;
  logic        tx_a, done_a, busy_a, tx_b, done_b, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .DVSR_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .full(full_a), .tx_start(start_a), .data_in(data_a),
    .dvsr(dvsr_a), .tx(tx_a), .tx_done(done_a), .busy(busy_a)
  );

  uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(1), .DVSR_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .full(full_b), .tx_start(start_b), .data_in(data_b),
    .dvsr(dvsr_b), .tx(tx_b), .tx_done(done_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected per-cycle outputs of one whole frame, followed by DONE and the
  // mandatory IDLE cycle in which start requests are not yet honoured.
  function automatic void build_frame(output exp_q_t q, input logic [7:0] d,
                                      input int dv, input int par, input int stops);
    int bits[$];
    q = {};
    bits.push_back(0);
    for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
    if (par != 0) bits.push_back(int'((^d) ^ (par == 2)));
    for (int i = 0; i < stops; i++) bits.push_back(1);
    foreach (bits[k]) begin
      for (int r = 0; r <= dv; r++) q.push_back({bits[k] != 0, 1'b1, 1'b0});
    end
    q.push_back(3'b111);
    q.push_back(EXP_IDLE);
  endfunction

  exp_q_t q_a, q_b;
  exp_t   exp_a = EXP_IDLE, exp_b = EXP_IDLE;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a.delete();
      exp_a = EXP_IDLE;
    end else if (q_a.size() > 0) begin
      exp_a = q_a.pop_front();
    end else if (full_a && start_a) begin
      build_frame(q_a, data_a, int'(dvsr_a), 0, 1);
      exp_a = q_a.pop_front();
    end else begin
      exp_a = EXP_IDLE;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_b.delete();
      exp_b = EXP_IDLE;
    end else if (q_b.size() > 0) begin
      exp_b = q_b.pop_front();
    end else if (full_b && start_b) begin
      build_frame(q_b, data_b, int'(dvsr_b), 1, 2);
      exp_b = q_b.pop_front();
    end else begin
      exp_b = EXP_IDLE;
    end
  end

  always @(negedge clk) begin
    check($sformatf("model A @%0t", $time), {tx_a, busy_a, done_a}, exp_a);
    check($sformatf("model B @%0t", $time), {tx_b, busy_b, done_b}, exp_b);
  end

  function automatic exp_t outs(input bit inst);
    return inst ? {tx_b, busy_b, done_b} : {tx_a, busy_a, done_a};
  endfunction

  task automatic set_full(input bit inst, input logic v);
    if (inst) full_b = v;
    else      full_a = v;
  endtask

  task automatic wait_fall(input bit inst, input string name);
    bit   seen = 1'b0;
    exp_t o;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      o = outs(inst);
      if (o[2] == 1'b0) seen = 1'b1;
    end
    check({name, " start bit seen"}, 32'(seen), 32'd1);
  endtask

  // pat[i] is the i-th transmitted bit in time order; samples mid-bit.
  task automatic check_frame(input bit inst, input string name, input int nbits,
                             input int bclk, input logic [11:0] pat,
                             input bit drop_full, input int change_at);
    int   done_at = -1;
    int   done_cnt = 0;
    exp_t o;
    wait_fall(inst, name);
    for (int c = 0; c <= nbits * bclk + 3; c++) begin
      if (c > 0) @(negedge clk);
      o = outs(inst);
      if (drop_full && c == 0) set_full(inst, 1'b0);
      if (c == change_at) begin
        dvsr_a  = 32'd9;
        data_a  = 8'hFF;
        start_a = 1'b0;
        full_a  = 1'b0;
      end
      if (c < nbits * bclk && (c % bclk) == bclk / 2)
        check($sformatf("%s bit%0d", name, c / bclk), 32'(o[2]), 32'(pat[c / bclk]));
      if (o[0]) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    check({name, " tx_done offset"}, done_at, nbits * bclk);
    check({name, " tx_done count"}, done_cnt, 1);
  endtask

  logic [11:0] b2b_pat;
  exp_t        o_main;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("reset idle", {tx_a, busy_a, done_a}, EXP_IDLE);
    end

    // 8N1, 0xA5, 4 clocks per bit: {stop, A5, start} = 12'h34A.
    data_a = 8'hA5; dvsr_a = 32'd3; full_a = 1'b1; start_a = 1'b1;
    check_frame(1'b0, "8N1", 10, 4, 12'h34A, 1'b1, -1);

    // 8E2, 0x07, 1 clock per bit: 0,1,1,1,0,0,0,0,0,1,1,1.
    data_b = 8'h07; dvsr_b = 32'd0; full_b = 1'b1; start_b = 1'b1;
    check_frame(1'b1, "8E2", 12, 1, 12'hE0E, 1'b1, -1);

    // Reset during data bit 3 of 0xA5 (a zero bit), then a fresh frame.
    data_a = 8'hA5; dvsr_a = 32'd3; full_a = 1'b1; start_a = 1'b1;
    wait_fall(1'b0, "rst");
    repeat (17) @(negedge clk);
    check("pre-reset tx", 32'(tx_a), 32'd0);
    #2 rst_n = 1'b0;
    #1 o_main = outs(1'b0);
    check("async reset outs", 32'(o_main), 32'(EXP_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(1'b0, "after rst", 10, 4, 12'h34A, 1'b1, -1);

    // Inputs change mid-frame; frame keeps 0x0F at 4 clocks per bit.
    data_a = 8'h0F; dvsr_a = 32'd3; full_a = 1'b1; start_a = 1'b1;
    check_frame(1'b0, "midchg", 10, 4, 12'h21E, 1'b0, 5);
    data_a = 8'h81; full_a = 1'b1; start_a = 1'b1;
    check_frame(1'b0, "dvsr9", 10, 10, 12'h302, 1'b1, -1);

    // Back-to-back: 0x55 then 0x3C written during DONE, 2 clocks per bit.
    data_a = 8'h55; dvsr_a = 32'd1; full_a = 1'b1; start_a = 1'b1;
    b2b_pat = 12'h278;
    wait_fall(1'b0, "b2b");
    for (int c = 0; c <= 44; c++) begin
      if (c > 0) @(negedge clk);
      o_main = outs(1'b0);
      if (c == 20) begin
        check("b2b first done", 32'(o_main[0]), 32'd1);
        data_a = 8'h3C;
      end
      if (c == 21) check("b2b idle gap", 32'(o_main), 32'(EXP_IDLE));
      if (c == 22) begin
        check("b2b second start", 32'(o_main[2]), 32'd0);
        full_a = 1'b0;
      end
      if (c >= 22 && c < 42 && ((c - 22) % 2) == 1)
        check($sformatf("b2b bit%0d", (c - 22) / 2), 32'(o_main[2]), 32'(b2b_pat[(c - 22) / 2]));
      if (c == 42) check("b2b second done", 32'(o_main[0]), 32'd1);
    end

    // full without tx_start must not start a frame.
    full_a = 1'b1; start_a = 1'b0;
    repeat (30) @(negedge clk);
    check("no start busy", 32'(busy_a), 32'd0);
    check("no start tx", 32'(tx_a), 32'd1);
    full_a = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit sequencer for the memory-mapped UART register block.
- Consumes the register block's byte (`data_out`), divisor (`dvsr`), enable (`tx_start`) and `full` flag.
- Generates bit timing and drives the serial TX line; returns a one-cycle `tx_done` pulse, which the register block uses to clear `full`.
- Sits between the UART register file and the top-level `tx` pin.

Parameters:
- DATA_BITS, 8, payload bits per frame (LSB first); legal values 5..8.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- DVSR_W, 32, width of the divisor input.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- full  in  1  register block has a byte pending.
- tx_start  in  1  transmitter enable from the control register.
- data_in  in  8  byte to send; bits above DATA_BITS-1 are ignored.
- dvsr  in  DVSR_W  clocks per bit minus one.
- tx  out  1  serial output; idle level is 1.
- tx_done  out  1  one-cycle pulse at end of frame.
- busy  out  1  high from frame start until end of DONE.

Behaviour:
- Reset (async, rst_n=0):
  - tx=1, tx_done=0, busy=0, state=IDLE, all counters and shift register cleared.
  - Takes effect immediately, including mid-frame; the frame is abandoned with no tx_done.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - tx=1, busy=0.
  - On a rising edge with full=1 and tx_start=1: latch data_in into the shift register and dvsr into dvsr_q; load bit counter with dvsr_q; go to START.
- Bit timing:
  - Down-counter loaded with dvsr_q at each bit boundary; the bit ends on the cycle the counter equals 0.
  - Each bit lasts dvsr_q+1 clocks; dvsr=0 gives 1 clock per bit.
  - dvsr=all-ones must not overflow.
- START: tx=0 for one bit period, then DATA.
- DATA:
  - tx=shift[0]; shift right at each bit end.
  - Bit index counts 0..DATA_BITS-1; after the last bit go to PARITY if PARITY!=0, else STOP.
- PARITY: tx = XOR of the latched payload bits (even), inverted for odd; one bit period.
- STOP: tx=1 for STOP_BITS bit periods, then DONE.
- DONE:
  - Exactly one cycle: tx=1, tx_done=1, busy=1, then IDLE.
  - Start conditions are ignored in DONE. This gives the register block (negedge-updated) time to clear full before the next IDLE sample.
- Latency:
  - tx falls on the edge after the IDLE start sample (registered output).
  - tx_done is asserted (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*(dvsr_q+1) cycles after tx first goes low.
- Mid-frame changes:
  - Changes to data_in, dvsr, full or tx_start during a frame have no effect on that frame.
  - Deasserting tx_start mid-frame does not abort.
- Back-to-back frames:
  - If full is still 1 in IDLE after DONE (CPU wrote a new byte in the DONE cycle, so the register block ignored tx_done), a new frame starts immediately.
  - The idle gap is then DONE + 1 IDLE cycle at tx=1.
- tx, tx_done and busy are all registered outputs (no combinational path from inputs).

Decomposition:
- uart_pkg:
  - state enum uart_tx_state_e;
  - parity constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - localparam for max frame bit count.
- Sub-module uart_baud_cnt:
  - DVSR_W down-counter with load, enable and a `tick` output;
  - instantiated once inside uart_tx_ctrl.

Test Plan:
- Reset value: rst_n=0 then 1, full=0 -> tx=1, busy=0, tx_done=0 held for 50 cycles.
- Basic frame, 8N1: dvsr=3, data_in=0xA5, full=1, tx_start=1.
  - tx low 4 clks, then data bits 1,0,1,0,0,1,0,1 at 4 clks each, then high 4 clks.
  - tx_done pulses exactly once, 40 clks after tx falls.
- Parity and stop: PARITY=1, STOP_BITS=2, dvsr=0, data_in=0x07.
  - Bit sequence 0,1,1,1,0,0,0,0,0,1,1,1, one clk each.
  - tx_done at clk 12.
- Mid-frame reset: assert rst_n=0 during data bit 3.
  - tx=1 asynchronously, no tx_done.
  - After release with full=1, a fresh full frame starts.
- Mid-frame input changes: change dvsr 3->9 and data_in during the frame.
  - Current frame keeps 4-clk bits and the original byte.
  - The next frame uses 10-clk bits.
- Back-to-back: keep full=1 through DONE (new byte 0x3C written in that cycle).
  - Second START begins 2 clks after tx_done.
  - tx_start=0 with full=1 -> no frame, busy=0.
